aes_sector_scheduler: RTL and testbench

Sequences the shared AES round core across whole SD-card sectors and arbitrates it between two requesters: the write path (host-to-card, encrypt) and the read path (card-to-host, decrypt). It sits between the sector buffers and the AES core controller. On each grant it issues one start pulse per 16-byte block, tracks the core busy flag, counts blocks, and reports block and sector completion.

---
 rtl/aes_sched_pkg.sv | 19 +
 rtl/aes_sched_rr_arb.sv | 28 ++
 rtl/aes_sector_scheduler.sv | 141 ++++++++++++++
 tb/tb_aes_sector_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared state encoding and mode constants for the AES sector scheduler.
package aes_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GRANT,
    WAIT_DATA,
    START,
    WAIT_BUSY,
    RUN,
    BLK_DONE,
    SECTOR_DONE,
    ERROR
  } sched_state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/aes_sched_rr_arb.sv
// 2-way round-robin arbiter: bit 0 = encrypt path, bit 1 = decrypt path.
module aes_sched_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // Reset as if decrypt went last, so encrypt wins the first contention.
  logic last_dec;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_dec ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        last_dec <= 1'b1;
    else if (update && gnt != 2'b00) last_dec <= gnt[1];
  end

endmodule

// File: rtl/aes_sector_scheduler.sv
// Sector-level sequencer and enc/dec arbiter for the shared AES core.
// Optional busy watchdog: define AES_SCHED_TIMEOUT_EN.
module aes_sector_scheduler
  import aes_sched_pkg::*;
#(
  parameter int BLOCKS_PER_SECTOR = 32,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_enc,
  input  logic                                 req_dec,
  input  logic                                 blk_ready,
  input  logic                                 core_busy,
  output logic                                 grant_enc,
  output logic                                 grant_dec,
  output logic                                 core_start,
  output logic                                 core_mode,
  output logic [$clog2(BLOCKS_PER_SECTOR)-1:0] blk_index,
  output logic                                 blk_done,
  output logic                                 sector_done,
  output logic                                 sched_busy,
  output logic                                 timeout_err
);

  localparam int            IW       = $clog2(BLOCKS_PER_SECTOR);
  localparam logic [IW-1:0] LAST_BLK = IW'(BLOCKS_PER_SECTOR - 1);

  sched_state_e state;
  logic [1:0]   arb_gnt;
  logic         arb_upd;

  assign arb_upd = (state == IDLE) && (req_enc || req_dec);

  aes_sched_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req_dec, req_enc}),
    .update (arb_upd),
    .gnt    (arb_gnt)
  );

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_wait;

  // True while the FSM stays put waiting on the core; any transition clears the count.
  assign tmo_wait = ((state == WAIT_BUSY) && !core_busy) || ((state == RUN) && core_busy);
`else
  wire unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_enc   <= 1'b0;
      grant_dec   <= 1'b0;
      core_start  <= 1'b0;
      core_mode   <= MODE_ENC;
      blk_index   <= '0;
      blk_done    <= 1'b0;
      sector_done <= 1'b0;
      sched_busy  <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      core_start  <= 1'b0;
      blk_done    <= 1'b0;
      sector_done <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
      tmo_cnt     <= tmo_wait ? tmo_cnt + 1'b1 : '0;
      if (tmo_wait && tmo_cnt == TMO_LAST) begin
        state       <= ERROR;
        timeout_err <= 1'b1;
        grant_enc   <= 1'b0;
        grant_dec   <= 1'b0;
        core_mode   <= MODE_ENC;
        blk_index   <= '0;
      end else
`endif
      case (state)
        IDLE: begin
          if (req_enc || req_dec) begin
            state      <= GRANT;
            grant_enc  <= arb_gnt[0];
            grant_dec  <= arb_gnt[1];
            core_mode  <= arb_gnt[1] ? MODE_DEC : MODE_ENC;
            sched_busy <= 1'b1;
          end
        end
        GRANT: state <= WAIT_DATA;
        WAIT_DATA: begin
          if (blk_ready) begin
            state      <= START;
            core_start <= 1'b1;
          end
        end
        START: state <= WAIT_BUSY;
        WAIT_BUSY: if (core_busy) state <= RUN;
        RUN: begin
          if (!core_busy) begin
            state    <= BLK_DONE;
            blk_done <= 1'b1;
          end
        end
        BLK_DONE: begin
          if (blk_index == LAST_BLK) begin
            state       <= SECTOR_DONE;
            sector_done <= 1'b1;
          end else begin
            state     <= WAIT_DATA;
            blk_index <= blk_index + 1'b1;
          end
        end
        SECTOR_DONE: begin
          state      <= IDLE;
          blk_index  <= '0;
          grant_enc  <= 1'b0;
          grant_dec  <= 1'b0;
          core_mode  <= MODE_ENC;
          sched_busy <= 1'b0;
        end
`ifdef AES_SCHED_TIMEOUT_EN
        ERROR: begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sector_scheduler.sv
// Directed bench for aes_sector_scheduler with a simple busy-counter core model.
`timescale 1ns/1ps
module tb_aes_sector_scheduler;

  localparam int BPS = 32;

  logic clk = 1'b0;
  logic rst, req_enc, req_dec, blk_ready;
  logic core_busy = 1'b0;
  logic grant_enc, grant_dec, core_start, core_mode, blk_done, sector_done, sched_busy, timeout_err;
  logic [4:0] blk_index;

  int errors = 0;
  int checks = 0;

  int busy_len = 20;
  bit stuck    = 1'b0;
  int busy_cnt = 0;

  int n_start, n_blk, n_sec, n_tmo, exp_idx, idx_err, mode_err, both_err, seq_err, gnt_err;
  bit prev_blk;

  always #5 clk = ~clk;

  aes_sector_scheduler #(.BLOCKS_PER_SECTOR(BPS), .TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_enc     (req_enc),
    .req_dec     (req_dec),
    .blk_ready   (blk_ready),
    .core_busy   (core_busy),
    .grant_enc   (grant_enc),
    .grant_dec   (grant_dec),
    .core_start  (core_start),
    .core_mode   (core_mode),
    .blk_index   (blk_index),
    .blk_done    (blk_done),
    .sector_done (sector_done),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  // Core model: busy for busy_len cycles after each start pulse, or forever when stuck.
  always @(negedge clk) begin
    if (core_start) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    core_busy = stuck || (busy_cnt > 0);
  end

  // Event monitor; tasks compare its tallies against hand-computed totals.
  always @(negedge clk) begin
    if (rst) begin
      exp_idx  = 0;
      prev_blk = 1'b0;
    end else begin
      if (core_start) n_start++;
      if (blk_done) begin
        if (blk_index !== exp_idx[4:0]) idx_err++;
        exp_idx = (exp_idx + 1) % BPS;
        n_blk++;
      end
      if (sector_done) begin
        n_sec++;
        if (!prev_blk) seq_err++;
      end
      if (blk_done && sector_done) both_err++;
      if (grant_enc && grant_dec) gnt_err++;
      if (grant_enc && core_mode !== 1'b0) mode_err++;
      if (grant_dec && core_mode !== 1'b1) mode_err++;
      if (timeout_err) n_tmo++;
      prev_blk = blk_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    n_start = 0; n_blk = 0; n_sec = 0; n_tmo = 0; exp_idx = 0;
    idx_err = 0; mode_err = 0; both_err = 0; seq_err = 0; gnt_err = 0;
  endtask

  task automatic wait_sec(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (sector_done) ok = 1'b1;
    end
  endtask

  task automatic wait_blk(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (blk_done && blk_index == k[4:0]) ok = 1'b1;
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (core_start) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst = 1'b1; req_enc = 1'b0; req_dec = 1'b0; blk_ready = 1'b0;
    repeat (3) tick();
    outs = {grant_enc, grant_dec, core_start, core_mode, blk_done, sector_done, sched_busy, timeout_err};
    checks++; if (outs !== 8'h00) begin errors++; $display("FAIL reset_outs: got %b want 00000000", outs); end
    checks++; if (blk_index !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", blk_index); end
    rst = 1'b0;
    tick(); tick();
    outs = {grant_enc, grant_dec, core_start, core_mode, blk_done, sector_done, sched_busy, timeout_err};
    checks++; if (outs !== 8'h00) begin errors++; $display("FAIL idle_outs: got %b want 00000000", outs); end
  endtask

  task automatic test_contention();
    bit ok;
    clear_mon(); busy_len = 3; blk_ready = 1'b1;
    req_enc = 1'b1; req_dec = 1'b1;
    tick();
    checks++; if ({grant_enc, grant_dec} !== 2'b10) begin errors++; $display("FAIL contend1_grant: got %b want 10", {grant_enc, grant_dec}); end
    wait_sec(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL contend1_done: got timeout want sector_done"); end
    req_enc = 1'b0;
    tick();
    checks++; if ({grant_enc, grant_dec, sched_busy} !== 3'b000) begin errors++; $display("FAIL b2b_idle: got %b want 000", {grant_enc, grant_dec, sched_busy}); end
    tick();
    checks++; if ({grant_enc, grant_dec, core_mode} !== 3'b011) begin errors++; $display("FAIL contend2_grant: got %b want 011", {grant_enc, grant_dec, core_mode}); end
    wait_sec(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL contend2_done: got timeout want sector_done"); end
    req_dec = 1'b0;
    tick();
    req_enc = 1'b1; req_dec = 1'b1;
    tick();
    checks++; if ({grant_enc, grant_dec} !== 2'b10) begin errors++; $display("FAIL contend3_grant: got %b want 10", {grant_enc, grant_dec}); end
    wait_sec(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL contend3_done: got timeout want sector_done"); end
    req_enc = 1'b0; req_dec = 1'b0;
    tick();
    checks++; if (n_sec !== 3 || n_blk !== 3*BPS) begin errors++; $display("FAIL contend_counts: got sec=%0d blk=%0d want 3 96", n_sec, n_blk); end
    checks++; if (gnt_err !== 0 || mode_err !== 0) begin errors++; $display("FAIL contend_excl: got gnt_err=%0d mode_err=%0d want 0 0", gnt_err, mode_err); end
  endtask

  task automatic test_single_enc();
    bit ok;
    clear_mon(); busy_len = 20; blk_ready = 1'b1; req_enc = 1'b1;
    tick();
    checks++; if ({grant_enc, grant_dec, sched_busy, core_mode} !== 4'b1010) begin errors++; $display("FAIL enc_grant: got %b want 1010", {grant_enc, grant_dec, sched_busy, core_mode}); end
    wait_sec(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL enc_done: got timeout want sector_done"); end
    req_enc = 1'b0;
    tick();
    checks++; if (n_start !== BPS || n_blk !== BPS || n_sec !== 1) begin errors++; $display("FAIL enc_counts: got start=%0d blk=%0d sec=%0d want 32 32 1", n_start, n_blk, n_sec); end
    checks++; if (idx_err !== 0) begin errors++; $display("FAIL enc_index_seq: got %0d bad indices want 0", idx_err); end
    checks++; if (mode_err !== 0) begin errors++; $display("FAIL enc_mode: got %0d bad cycles want 0", mode_err); end
    checks++; if (both_err !== 0 || seq_err !== 0) begin errors++; $display("FAIL enc_done_order: got both=%0d seq=%0d want 0 0", both_err, seq_err); end
    checks++; if ({grant_enc, sched_busy, blk_index} !== 7'd0) begin errors++; $display("FAIL enc_release: got g=%b b=%b idx=%0d want 0 0 0", grant_enc, sched_busy, blk_index); end
  endtask

  task automatic test_stall();
    bit ok;
    int stall_starts;
    clear_mon(); busy_len = 3; blk_ready = 1'b1; req_enc = 1'b1;
    wait_blk(4, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_reach: got timeout want block 4 done"); end
    blk_ready = 1'b0;
    stall_starts = 0;
    repeat (10) begin
      tick();
      if (core_start) stall_starts++;
    end
    checks++; if (stall_starts !== 0) begin errors++; $display("FAIL stall_nostart: got %0d starts want 0", stall_starts); end
    checks++; if (blk_index !== 5'd5) begin errors++; $display("FAIL stall_idx: got %0d want 5", blk_index); end
    blk_ready = 1'b1;
    tick();
    checks++; if (core_start !== 1'b1 || blk_index !== 5'd5) begin errors++; $display("FAIL stall_resume: got start=%b idx=%0d want 1 5", core_start, blk_index); end
    wait_sec(1000, ok);
    req_enc = 1'b0;
    tick();
    checks++; if (!ok || n_blk !== BPS || idx_err !== 0) begin errors++; $display("FAIL stall_complete: got ok=%b blk=%0d idx_err=%0d want 1 32 0", ok, n_blk, idx_err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] outs;
    clear_mon(); busy_len = 20; blk_ready = 1'b1; req_enc = 1'b1;
    wait_blk(16, 2000, ok);
    repeat (6) tick();
    checks++; if (!ok || blk_index !== 5'd17 || core_busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got ok=%b idx=%0d busy=%b want 1 17 1", ok, blk_index, core_busy); end
    rst = 1'b1;
    #1;
    outs = {grant_enc, grant_dec, core_start, core_mode, blk_done, sector_done, sched_busy, timeout_err};
    checks++; if (outs !== 8'h00 || blk_index !== 5'd0) begin errors++; $display("FAIL midrst_async: got %b idx=%0d want 00000000 0", outs, blk_index); end
    req_enc = 1'b0;
    tick();
    outs = {grant_enc, grant_dec, core_start, core_mode, blk_done, sector_done, sched_busy, timeout_err};
    checks++; if (outs !== 8'h00 || blk_index !== 5'd0) begin errors++; $display("FAIL midrst_next: got %b idx=%0d want 00000000 0", outs, blk_index); end
    rst = 1'b0;
    tick();
    clear_mon(); busy_len = 3; req_enc = 1'b1;
    tick();
    checks++; if (grant_enc !== 1'b1 || blk_index !== 5'd0) begin errors++; $display("FAIL midrst_regrant: got g=%b idx=%0d want 1 0", grant_enc, blk_index); end
    wait_sec(1000, ok);
    req_enc = 1'b0;
    tick();
    checks++; if (!ok || n_blk !== BPS || idx_err !== 0) begin errors++; $display("FAIL midrst_restart: got ok=%b blk=%0d idx_err=%0d want 1 32 0", ok, n_blk, idx_err); end
  endtask

  task automatic test_drop_req();
    bit ok;
    clear_mon(); busy_len = 3; blk_ready = 1'b1; req_enc = 1'b1;
    wait_blk(3, 1000, ok);
    req_enc = 1'b0;
    checks++; if (!ok || grant_enc !== 1'b1) begin errors++; $display("FAIL drop_reach: got ok=%b g=%b want 1 1", ok, grant_enc); end
    wait_sec(1000, ok);
    tick();
    checks++; if (!ok || n_blk !== BPS || n_sec !== 1) begin errors++; $display("FAIL drop_complete: got ok=%b blk=%0d sec=%0d want 1 32 1", ok, n_blk, n_sec); end
    tick(); tick();
    checks++; if (grant_enc !== 1'b0 || sched_busy !== 1'b0) begin errors++; $display("FAIL drop_norestart: got g=%b b=%b want 0 0", grant_enc, sched_busy); end
  endtask

`ifdef AES_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, seen;
    int k;
    clear_mon(); busy_len = 3; blk_ready = 1'b1; req_enc = 1'b1;
    wait_start(50, ok);
    stuck = 1'b1;
    seen = 1'b0; k = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      k++;
      if (timeout_err) seen = 1'b1;
    end
    // START at cycle 0, WAIT_BUSY 1, RUN 2..65 (64 cycles), ERROR at 66.
    checks++; if (!ok || !seen || k !== 66) begin errors++; $display("FAIL tmo_latency: got ok=%b seen=%b k=%0d want 1 1 66", ok, seen, k); end
    checks++; if (grant_enc !== 1'b0) begin errors++; $display("FAIL tmo_grant: got %b want 0", grant_enc); end
    req_enc = 1'b0; stuck = 1'b0;
    tick();
    checks++; if (sched_busy !== 1'b0 || timeout_err !== 1'b0 || blk_index !== 5'd0) begin errors++; $display("FAIL tmo_idle: got b=%b t=%b idx=%0d want 0 0 0", sched_busy, timeout_err, blk_index); end
    checks++; if (n_sec !== 0 || n_tmo !== 1) begin errors++; $display("FAIL tmo_counts: got sec=%0d tmo=%0d want 0 1", n_sec, n_tmo); end
    repeat (5) tick();
  endtask
`else
  task automatic test_timeout();
    bit ok;
    clear_mon(); busy_len = 3; blk_ready = 1'b1; req_enc = 1'b1;
    wait_start(50, ok);
    stuck = 1'b1;
    repeat (150) tick();
    checks++; if (!ok || n_tmo !== 0 || timeout_err !== 1'b0) begin errors++; $display("FAIL notmo_err: got ok=%b tmo=%0d want 1 0", ok, n_tmo); end
    checks++; if (grant_enc !== 1'b1 || sched_busy !== 1'b1) begin errors++; $display("FAIL notmo_hold: got g=%b b=%b want 1 1", grant_enc, sched_busy); end
    stuck = 1'b0;
    wait_sec(1000, ok);
    req_enc = 1'b0;
    tick();
    checks++; if (!ok || n_blk !== BPS || n_sec !== 1) begin errors++; $display("FAIL notmo_complete: got ok=%b blk=%0d sec=%0d want 1 32 1", ok, n_blk, n_sec); end
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_contention();
    test_single_enc();
    test_stall();
    test_reset_mid();
    test_drop_req();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
